// File: rtl/rr_mux_arb_if.sv
// Handshake bundle for the arbitrated multiplexer: N producer channels in,
// one registered consumer channel out, plus the arbitration mode select.
interface rr_mux_arb_if #(
  parameter int N     = 4,
  parameter int WIDTH = 12
) ();
  localparam int SELW = $clog2(N);

  logic                 mode;
  logic [N-1:0]         in_valid;
  logic [N*WIDTH-1:0]   in_data;
  logic [N-1:0]         in_ready;
  logic                 out_valid;
  logic [WIDTH-1:0]     out_data;
  logic [SELW-1:0]      out_sel;
  logic                 out_ready;

  // Producer/consumer side: drives requests and consumer ready.
  modport master (
    output mode, in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_sel
  );

  // Arbiter side.
  modport slave (
    input  mode, in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_sel
  );
endinterface

// File: rtl/rr_mux_arb.sv
// N-channel arbitrated multiplexer with a single registered output stage.
// Grants one requesting channel per cycle (round-robin or fixed priority)
// and captures the winner's data together with its channel index.
module rr_mux_arb #(
  parameter int WIDTH = 12,
  parameter int N     = 4,
  localparam int SELW = $clog2(N)
) (
  input  logic          clk,
  input  logic          reset,
  rr_mux_arb_if.slave   bus
);

  logic                 load;
  logic [N-1:0]         rr_hi;
  logic [N-1:0]         rr_lo;
  logic [N-1:0]         fixed_gnt;
  logic [N-1:0]         grant;
  logic [SELW-1:0]      grant_sel;
  logic [WIDTH-1:0]     grant_data;
  logic [SELW-1:0]      last;
  logic                 out_valid_q;
  logic [WIDTH-1:0]     out_data_q;
  logic [SELW-1:0]      out_sel_q;

  // The output register can take a new word when empty or being drained.
  assign load = !out_valid_q || bus.out_ready;

  // Candidate grants: lowest requester above the pointer, lowest at or below
  // it (the wrapped half), and plain lowest index for fixed priority.
  always_comb begin
    rr_hi     = '0;
    rr_lo     = '0;
    fixed_gnt = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (bus.in_valid[i]) begin
        fixed_gnt    = '0;
        fixed_gnt[i] = 1'b1;
        if (i > int'(last)) begin
          rr_hi    = '0;
          rr_hi[i] = 1'b1;
        end else begin
          rr_lo    = '0;
          rr_lo[i] = 1'b1;
        end
      end
    end
  end

  // Final one-hot grant, suppressed whenever the output stage cannot load.
  always_comb begin
    grant = '0;
    if (load) begin
      if (bus.mode)
        grant = fixed_gnt;
      else if (|rr_hi)
        grant = rr_hi;
      else
        grant = rr_lo;
    end
  end

  // Encode the granted channel's index and pick out its data slice.
  always_comb begin
    grant_sel  = '0;
    grant_data = '0;
    for (int i = 0; i < N; i++) begin
      if (grant[i]) begin
        grant_sel  = SELW'(i);
        grant_data = bus.in_data[i*WIDTH +: WIDTH];
      end
    end
  end

  // Output register and round-robin pointer: load on a grant, empty on a
  // drain with nothing to refill, otherwise hold.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_sel_q   <= '0;
      last        <= SELW'(N - 1);
    end else if (|grant) begin
      out_valid_q <= 1'b1;
      out_data_q  <= grant_data;
      out_sel_q   <= grant_sel;
      last        <= grant_sel;
    end else if (bus.out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

  assign bus.in_ready  = grant;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_sel   = out_sel_q;

endmodule

// File: tb/tb_rr_mux_arb.sv
// Directed bench for rr_mux_arb: a 4x12 instance for the main scenarios and a
// 3x8 instance to exercise non-power-of-two wrap and data packing.
module tb_rr_mux_arb;

  logic clk;
  logic reset;
  int   vectors;
  int   miscompares;

  rr_mux_arb_if #(.N(4), .WIDTH(12)) bus4 ();
  rr_mux_arb_if #(.N(3), .WIDTH(8))  bus3 ();

  rr_mux_arb #(.WIDTH(12), .N(4)) dut4 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus4.slave)
  );

  rr_mux_arb #(.WIDTH(8), .N(3)) dut3 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus3.slave)
  );

  // Free-running clock, rising edges at 5, 15, 25 ...
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Pulse reset between clock edges so it acts purely asynchronously.
  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    #2;
    reset = 1'b0;
  endtask

  task automatic test_reset();
    bus4.mode = 1'b0; bus4.in_valid = '0; bus4.out_ready = 1'b1;
    bus4.in_data = {12'hA03, 12'hA02, 12'hA01, 12'hA00};
    reset = 1'b1;
    #3;
    vectors++; if (bus4.out_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_valid got %b want 0", bus4.out_valid); end
    vectors++; if (bus4.out_data !== 12'h000) begin miscompares++; $display("[TB] FAIL reset_data got %h want 000", bus4.out_data); end
    vectors++; if (bus4.out_sel !== 2'd0) begin miscompares++; $display("[TB] FAIL reset_sel got %0d want 0", bus4.out_sel); end
    @(negedge clk);
    reset = 1'b0;
    bus4.in_valid = 4'b1111;
    @(posedge clk); #1;
    vectors++; if (bus4.out_valid !== 1'b1) begin miscompares++; $display("[TB] FAIL pre_reset_valid got %b want 1", bus4.out_valid); end
    vectors++; if (bus4.out_sel !== 2'd0) begin miscompares++; $display("[TB] FAIL pre_reset_sel got %0d want 0", bus4.out_sel); end
    // Mid-cycle assertion while a word is held.
    #2;
    reset = 1'b1;
    #1;
    vectors++; if (bus4.out_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL async_valid got %b want 0", bus4.out_valid); end
    vectors++; if (bus4.out_data !== 12'h000) begin miscompares++; $display("[TB] FAIL async_data got %h want 000", bus4.out_data); end
    vectors++; if (bus4.out_sel !== 2'd0) begin miscompares++; $display("[TB] FAIL async_sel got %0d want 0", bus4.out_sel); end
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk); #1;
    vectors++; if (bus4.out_sel !== 2'd0) begin miscompares++; $display("[TB] FAIL post_reset_sel got %0d want 0", bus4.out_sel); end
    vectors++; if (bus4.out_data !== 12'hA00) begin miscompares++; $display("[TB] FAIL post_reset_data got %h want A00", bus4.out_data); end
    bus4.in_valid = '0;
  endtask

  task automatic test_round_robin();
    int seq [6] = '{0, 1, 2, 3, 0, 1};
    bus4.mode = 1'b0; bus4.in_valid = '0; bus4.out_ready = 1'b1;
    bus4.in_data = {12'hA03, 12'hA02, 12'hA01, 12'hA00};
    do_reset();
    bus4.in_valid = 4'b1111;
    for (int k = 0; k < 6; k++) begin
      #1;
      vectors++; if (bus4.in_ready !== 4'(1 << seq[k])) begin miscompares++; $display("[TB] FAIL rr_ready[%0d] got %b want %b", k, bus4.in_ready, 4'(1 << seq[k])); end
      @(posedge clk); #1;
      vectors++; if (bus4.out_valid !== 1'b1) begin miscompares++; $display("[TB] FAIL rr_valid[%0d] got %b want 1", k, bus4.out_valid); end
      vectors++; if (bus4.out_sel !== 2'(seq[k])) begin miscompares++; $display("[TB] FAIL rr_sel[%0d] got %0d want %0d", k, bus4.out_sel, seq[k]); end
      vectors++; if (bus4.out_data !== 12'(12'hA00 + seq[k])) begin miscompares++; $display("[TB] FAIL rr_data[%0d] got %h want %h", k, bus4.out_data, 12'(12'hA00 + seq[k])); end
      @(negedge clk);
    end
    bus4.in_valid = '0;
  endtask

  task automatic test_sparse_wrap();
    int seq [3] = '{0, 1, 0};
    bus4.mode = 1'b0; bus4.in_valid = '0; bus4.out_ready = 1'b1;
    bus4.in_data = {12'hA03, 12'hA02, 12'hA01, 12'hA00};
    do_reset();
    // Single transfer on channel 2 moves the pointer to 2.
    bus4.in_valid = 4'b0100;
    @(posedge clk); #1;
    vectors++; if (bus4.out_sel !== 2'd2) begin miscompares++; $display("[TB] FAIL sparse_setup got %0d want 2", bus4.out_sel); end
    @(negedge clk);
    bus4.in_valid = 4'b0011;
    for (int k = 0; k < 3; k++) begin
      #1;
      vectors++; if (bus4.in_ready !== 4'(1 << seq[k])) begin miscompares++; $display("[TB] FAIL sparse_ready[%0d] got %b want %b", k, bus4.in_ready, 4'(1 << seq[k])); end
      @(posedge clk); #1;
      vectors++; if (bus4.out_sel !== 2'(seq[k])) begin miscompares++; $display("[TB] FAIL sparse_sel[%0d] got %0d want %0d", k, bus4.out_sel, seq[k]); end
      @(negedge clk);
    end
    bus4.in_valid = '0;
  endtask

  task automatic test_backpressure();
    bus4.mode = 1'b0; bus4.in_valid = '0; bus4.out_ready = 1'b1;
    bus4.in_data = {12'hB03, 12'hB02, 12'h5A5, 12'hB00};
    do_reset();
    bus4.in_valid = 4'b0010;
    @(posedge clk); #1;
    vectors++; if (bus4.out_data !== 12'h5A5) begin miscompares++; $display("[TB] FAIL bp_load got %h want 5A5", bus4.out_data); end
    @(negedge clk);
    bus4.out_ready = 1'b0;
    bus4.in_valid  = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      #1;
      vectors++; if (bus4.in_ready !== 4'b0000) begin miscompares++; $display("[TB] FAIL bp_ready[%0d] got %b want 0000", k, bus4.in_ready); end
      @(posedge clk); #1;
      vectors++; if (bus4.out_valid !== 1'b1 || bus4.out_data !== 12'h5A5 || bus4.out_sel !== 2'd1) begin
        miscompares++;
        $display("[TB] FAIL bp_hold[%0d] got v=%b d=%h s=%0d want v=1 d=5A5 s=1", k, bus4.out_valid, bus4.out_data, bus4.out_sel);
      end
      @(negedge clk);
    end
    bus4.out_ready = 1'b1;
    #1;
    vectors++; if (bus4.in_ready !== 4'b0100) begin miscompares++; $display("[TB] FAIL bp_release_ready got %b want 0100", bus4.in_ready); end
    @(posedge clk); #1;
    vectors++; if (bus4.out_valid !== 1'b1 || bus4.out_data !== 12'hB02 || bus4.out_sel !== 2'd2) begin
      miscompares++;
      $display("[TB] FAIL bp_refill got v=%b d=%h s=%0d want v=1 d=B02 s=2", bus4.out_valid, bus4.out_data, bus4.out_sel);
    end
    bus4.in_valid = '0;
  endtask

  task automatic test_fixed_priority();
    int seq [3] = '{2, 3, 1};
    bus4.mode = 1'b1; bus4.in_valid = '0; bus4.out_ready = 1'b1;
    bus4.in_data = {12'hC03, 12'hC02, 12'hC01, 12'hC00};
    do_reset();
    bus4.in_valid = 4'b1110;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      vectors++; if (bus4.out_sel !== 2'd1) begin miscompares++; $display("[TB] FAIL fixed_sel[%0d] got %0d want 1", k, bus4.out_sel); end
    end
    @(negedge clk);
    bus4.mode = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      vectors++; if (bus4.out_sel !== 2'(seq[k])) begin miscompares++; $display("[TB] FAIL switch_sel[%0d] got %0d want %0d", k, bus4.out_sel, seq[k]); end
    end
    // Drain with nothing to refill: valid drops, word and index are kept.
    @(negedge clk);
    bus4.in_valid = '0;
    @(posedge clk); #1;
    vectors++; if (bus4.out_valid !== 1'b0 || bus4.out_data !== 12'hC01 || bus4.out_sel !== 2'd1) begin
      miscompares++;
      $display("[TB] FAIL drain got v=%b d=%h s=%0d want v=0 d=C01 s=1", bus4.out_valid, bus4.out_data, bus4.out_sel);
    end
  endtask

  task automatic test_generics();
    int seq [4] = '{0, 1, 2, 0};
    bus3.mode = 1'b0; bus3.in_valid = '0; bus3.out_ready = 1'b1;
    bus3.in_data = {8'h32, 8'h31, 8'h30};
    do_reset();
    bus3.in_valid = 3'b111;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      vectors++; if (bus3.out_sel !== 2'(seq[k])) begin miscompares++; $display("[TB] FAIL gen_sel[%0d] got %0d want %0d", k, bus3.out_sel, seq[k]); end
      vectors++; if (bus3.out_data !== 8'(8'h30 + seq[k])) begin miscompares++; $display("[TB] FAIL gen_data[%0d] got %h want %h", k, bus3.out_data, 8'(8'h30 + seq[k])); end
    end
    @(negedge clk);
    bus3.in_valid = '0;
  endtask

  // Scenario sequence and summary.
  initial begin
    vectors     = 0;
    miscompares = 0;
    bus3.mode = 1'b0; bus3.in_valid = '0; bus3.in_data = '0; bus3.out_ready = 1'b1;
    test_reset();
    test_round_robin();
    test_sparse_wrap();
    test_backpressure();
    test_fixed_priority();
    test_generics();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
